// File: rtl/quiz_gen.sv
// quiz_gen: shows a key value for a selected node, randomly swapped for a neighbour, and scores yes/no answers.
// Optional build macro QUIZ_TIMEOUT_EN adds a TIMEOUT_CYC-cycle answer window to the SHOW state.
module quiz_gen #(
  parameter int unsigned W           = 8,
  parameter int unsigned N           = 7,
  parameter int unsigned IDX_W       = 3,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned TIMEOUT_CYC = 250000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   all_keys,
  input  logic [IDX_W-1:0] index,
  input  logic             valid,
  input  logic             answer_valid,
  input  logic             answer_yes,
  output logic [W-1:0]     game_value,
  output logic             is_correct,
  output logic             q_valid,
  output logic             result_valid,
  output logic             result_hit,
  output logic             timeout,
  output logic [7:0]       score,
  output logic [3:0]       streak
);

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  if (N < 2 || N > 16 || (1 << IDX_W) < N || SEED == 16'h0000 || TIMEOUT_CYC == 0) begin : g_bad_params
    $error("quiz_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, GEN, SHOW} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic             valid_q;
  logic             armed;
  logic [IDX_W-1:0] idx;

  logic             valid_rise_c;
  logic             index_ok_c;
  logic [15:0]      lfsr_next_c;
  logic [IDX_W-1:0] d_c;
  logic [W-1:0]     key_idx_c;
  logic [W-1:0]     key_d_c;
  logic             judge_c;
  logic             judge_hit_c;
  logic             judge_to_c;

`ifdef QUIZ_TIMEOUT_EN
  localparam int unsigned TC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TC_W-1:0] tcnt;
`endif

  // A level held high across reset must be seen low once before it can count as an edge.
  assign valid_rise_c = valid & ~valid_q & armed;
  assign index_ok_c   = {1'b0, index} < (IDX_W+1)'(N);
  assign lfsr_next_c  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

  // Decoy node: lfsr[0] picks real/decoy, lfsr[1] picks next/previous neighbour with wrap.
  always_comb begin
    d_c = idx;
    if (lfsr[0]) begin
      if (!lfsr[1]) d_c = (idx == IDX_W'(N-1)) ? IDX_W'(0) : idx + IDX_W'(1);
      else          d_c = (idx == IDX_W'(0))   ? IDX_W'(N-1) : idx - IDX_W'(1);
    end
  end

  always_comb begin
    key_idx_c = '0;
    key_d_c   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) key_idx_c = all_keys[i*W +: W];
      if (d_c == IDX_W'(i)) key_d_c   = all_keys[i*W +: W];
    end
  end

  // An answer always wins over the window expiring in the same cycle.
  always_comb begin
    judge_c     = 1'b0;
    judge_hit_c = 1'b0;
    judge_to_c  = 1'b0;
    if (state == SHOW) begin
      if (answer_valid) begin
        judge_c     = 1'b1;
        judge_hit_c = (answer_yes == is_correct);
      end
`ifdef QUIZ_TIMEOUT_EN
      else if (valid && tcnt == TC_W'(TIMEOUT_CYC-1)) begin
        judge_c    = 1'b1;
        judge_to_c = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED;
      valid_q      <= 1'b0;
      armed        <= 1'b0;
      idx          <= '0;
      game_value   <= '0;
      is_correct   <= 1'b0;
      q_valid      <= 1'b0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      timeout      <= 1'b0;
      score        <= '0;
      streak       <= '0;
`ifdef QUIZ_TIMEOUT_EN
      tcnt         <= '0;
`endif
    end else begin
      lfsr         <= lfsr_next_c;
      valid_q      <= valid;
      if (!valid) armed <= 1'b1;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_rise_c && index_ok_c) begin
            idx   <= index;
            state <= GEN;
          end
        end
        GEN: begin
          game_value <= key_d_c;
          is_correct <= (key_d_c == key_idx_c);
          q_valid    <= 1'b1;
          state      <= SHOW;
`ifdef QUIZ_TIMEOUT_EN
          tcnt       <= '0;
`endif
        end
        SHOW: begin
          if (judge_c) begin
            result_valid <= 1'b1;
            result_hit   <= judge_hit_c;
            timeout      <= judge_to_c;
            if (judge_hit_c) begin
              if (score != 8'hFF) score <= score + 8'd1;
              if (streak != 4'hF) streak <= streak + 4'd1;
            end else begin
              streak <= '0;
            end
            q_valid <= 1'b0;
            state   <= IDLE;
          end else if (!valid) begin
            q_valid <= 1'b0;
            state   <= IDLE;
          end
`ifdef QUIZ_TIMEOUT_EN
          else begin
            tcnt <= tcnt + TC_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/quiz_gen.md
QUIZ_GEN -- requirements
Module: quiz_gen

Interface
REQ-001 SHALL provide parameter W, default 8: bit width of one key.
REQ-002 SHALL provide parameter N, default 7: number of nodes, legal range 2..16.
REQ-003 SHALL provide parameter IDX_W, default 3: index width, with 2^IDX_W >= N.
REQ-004 SHALL provide parameter SEED, default 16'hACE1: LFSR reset value, nonzero.
REQ-005 SHALL provide parameter TIMEOUT_CYC, default 250000000: answer window in cycles, used only under QUIZ_TIMEOUT_EN.
REQ-006 Port clk, input, 1: system clock; all state changes on posedge.
REQ-007 Port rst, input, 1: reset, asynchronous and active-high.
REQ-008 Port all_keys, input, N*W: level-order keys; node k occupies bits [k*W+W-1 : k*W].
REQ-009 Port index, input, IDX_W: selected node.
REQ-010 Port valid, input, 1: selection request; level-sensitive, edge-detected internally.
REQ-011 Port answer_valid, input, 1: one-cycle user answer strobe.
REQ-012 Port answer_yes, input, 1: user claims the shown value is correct; sampled with answer_valid.
REQ-013 Port game_value, output, W: displayed question value.
REQ-014 Port is_correct, output, 1: whether game_value equals the key of the selected node.
REQ-015 Port q_valid, output, 1: a question is pending.
REQ-016 Port result_valid, output, 1: one-cycle pulse marking a judged answer.
REQ-017 Port result_hit, output, 1: judged answer was right; meaningful only while result_valid is high.
REQ-018 Port timeout, output, 1: the judged result came from the timeout path.
REQ-019 Port score, output, 8: count of hits.
REQ-020 Port streak, output, 4: consecutive hits.

Function
REQ-021 SHALL run a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) that advances every cycle in every state.
REQ-022 SHALL use FSM states IDLE, GEN, SHOW.
REQ-023 IDLE->GEN SHALL occur on a valid rising edge (valid=1, previous-cycle valid=0) only when index<N; when index>=N, no transition occurs and all outputs are unchanged.
REQ-024 SHALL latch index on the IDLE->GEN transition.
REQ-025 GEN SHALL last exactly one cycle; game_value/is_correct SHALL update at its end, with q_valid=1 in the next cycle (2-cycle latency from the valid edge).
REQ-026 GEN, when lfsr[0]=0: game_value=key[idx] and is_correct=1.
REQ-027 GEN, when lfsr[0]=1: game_value=key[d]; d=(idx+1) mod N if lfsr[1]=0, else (idx+N-1) mod N.
REQ-028 GEN: is_correct SHALL equal (key[d]==key[idx]), so duplicate keys are judged correct.
REQ-029 In SHOW, an answer_valid cycle SHALL produce result_valid=1 in the next cycle with result_hit=(answer_yes==is_correct), then return to IDLE with q_valid=0.
REQ-030 On a hit: score+1, saturating at 255; streak+1, saturating at 15.
REQ-031 On a miss: score held; streak cleared to 0.
REQ-032 valid=0 while in SHOW with no answer_valid SHALL abort to IDLE: no result, score and streak unchanged.
REQ-033 answer_valid together with valid=0 in the same cycle: the answer SHALL be judged.
REQ-034 answer_valid outside SHOW SHALL be ignored.
REQ-035 game_value and is_correct SHALL hold their value after judging or abort until the next GEN.
REQ-036 A new question SHALL require valid to drop and rise again.

Reset
REQ-037 While rst=1, all outputs and counters SHALL be 0 at once, without waiting for a clk edge.
REQ-038 While rst=1: state=IDLE, LFSR=SEED, stored previous valid=0.
REQ-039 After rst is released, valid already high SHALL NOT count as a rising edge.
REQ-040 rst in any state SHALL discard the pending question without emitting a result.

Configuration
REQ-041 With QUIZ_TIMEOUT_EN defined: a SHOW cycle counter SHALL run, and TIMEOUT_CYC cycles without an answer SHALL produce result_valid=1, result_hit=0, timeout=1 (miss rules applied), then return to IDLE.
REQ-042 With QUIZ_TIMEOUT_EN defined: an answer on the final window cycle SHALL take priority over the timeout.
REQ-043 With QUIZ_TIMEOUT_EN undefined: SHOW SHALL wait indefinitely, timeout SHALL be tied 0, and no counter logic SHALL be present.

Verification
Common setup for all scenarios: N=7, W=8, keys k0..k6 = 10,20,...,70.
REQ-044 Forced lfsr[0]=0, index=3, valid rises -> after 2 cycles game_value=40, is_correct=1, q_valid=1; answer_yes=1 -> result_hit=1, score=1, streak=1.
REQ-045 Forced lfsr[1:0]=2'b01, index=6 -> game_value=10 (wrap to node 0), is_correct=0; answer_yes=1 -> result_hit=0, streak=0.
REQ-046 Forced lfsr[1:0]=2'b11, index=0 -> game_value=70; separately, keys k0=k1=10, index=0, d=1 -> is_correct=1.
REQ-047 index=7 with valid rising -> no q_valid; valid dropped mid-SHOW -> q_valid=0, no result_valid, score unchanged.
REQ-048 Preload score=255, streak=15, then a hit -> score stays 255, streak stays 15; rst pulsed mid-SHOW -> all outputs 0 immediately.
REQ-049 With QUIZ_TIMEOUT_EN and TIMEOUT_CYC=10: no answer -> result_valid=1, timeout=1 after 10 SHOW cycles; answer on cycle 10 -> timeout=0.
